// File: rtl/ctrl_tx_if.sv
// Request / UART-TX bundle for the transmit-side controller.
//   rf_data, rf_vld    : register-file read result and its one-cycle qualifier
//   alu_data, alu_vld  : ALU result and its one-cycle qualifier
//   tx_busy            : UART TX busy, already synchronised to clk
//   tx_p_data, tx_d_vld: byte and valid presented to the UART TX
//   ctrl_busy          : frame in progress or request pending
//   req_ovf            : sticky, a request was dropped
// The slave modport is the controller; the master modport is its environment.
interface ctrl_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] rf_data;
    logic                  rf_vld;
    logic [ALU_WIDTH-1:0]  alu_data;
    logic                  alu_vld;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_d_vld;
    logic                  ctrl_busy;
    logic                  req_ovf;

    modport master (
        output rf_data, rf_vld, alu_data, alu_vld, tx_busy,
        input  tx_p_data, tx_d_vld, ctrl_busy, req_ovf
    );

    modport slave (
        input  rf_data, rf_vld, alu_data, alu_vld, tx_busy,
        output tx_p_data, tx_d_vld, ctrl_busy, req_ovf
    );
endinterface

// File: rtl/ctrl_tx.sv
// Transmit-side system controller. Serialises RF (1 byte) and ALU (2 bytes, low
// byte first) results into bytes for the UART TX over a valid/busy handshake.
// Ports:
//   clk : reference clock
//   rst : asynchronous active-low reset
//   bus : ctrl_tx_if.slave (requests in, UART byte/valid and status out)
module ctrl_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
) (
    input logic      clk,
    input logic      rst,
    ctrl_tx_if.slave bus
);
    localparam int PadW = ALU_WIDTH - DATA_WIDTH;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSend     = 2'd1;
    localparam logic [1:0] StWaitDone = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ALU_WIDTH-1:0]  shreg_q, shreg_d;
    logic                  bcnt_q, bcnt_d;
    logic [1:0]            blen_q, blen_d;
    logic                  rf_pend_q, rf_pend_d;
    logic [DATA_WIDTH-1:0] rf_slot_q, rf_slot_d;
    logic                  alu_pend_q, alu_pend_d;
    logic [ALU_WIDTH-1:0]  alu_slot_q, alu_slot_d;
    logic                  req_ovf_q, req_ovf_d;

    logic idle_free, rf_direct, alu_direct, frame_done;
    logic consume_rf, consume_alu;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        blen_d      = blen_q;
        rf_pend_d   = rf_pend_q;
        rf_slot_d   = rf_slot_q;
        alu_pend_d  = alu_pend_q;
        alu_slot_d  = alu_slot_q;
        req_ovf_d   = req_ovf_q;
        consume_rf  = 1'b0;
        consume_alu = 1'b0;

        idle_free  = (state_q == StIdle) && !rf_pend_q && !alu_pend_q;
        rf_direct  = idle_free && bus.rf_vld;
        // On a simultaneous pulse RF takes the shift register, ALU is parked.
        alu_direct = idle_free && bus.alu_vld && !bus.rf_vld;
        frame_done = ({1'b0, bcnt_q} == (blen_q - 2'd1));

        case (state_q)
            StIdle: begin
                // A request parked on the very edge the previous frame ended
                // is launched from here.
                if (rf_pend_q) begin
                    shreg_d    = {{PadW{1'b0}}, rf_slot_q};
                    blen_d     = 2'd1;
                    bcnt_d     = 1'b0;
                    consume_rf = 1'b1;
                    state_d    = StSend;
                end else if (alu_pend_q) begin
                    shreg_d     = alu_slot_q;
                    blen_d      = 2'd2;
                    bcnt_d      = 1'b0;
                    consume_alu = 1'b1;
                    state_d     = StSend;
                end else if (rf_direct) begin
                    shreg_d = {{PadW{1'b0}}, bus.rf_data};
                    blen_d  = 2'd1;
                    bcnt_d  = 1'b0;
                    state_d = StSend;
                end else if (alu_direct) begin
                    shreg_d = bus.alu_data;
                    blen_d  = 2'd2;
                    bcnt_d  = 1'b0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (bus.tx_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    if (!frame_done) begin
                        shreg_d = shreg_q >> DATA_WIDTH;
                        bcnt_d  = bcnt_q + 1'b1;
                        state_d = StSend;
                    end else if (rf_pend_q) begin
                        shreg_d    = {{PadW{1'b0}}, rf_slot_q};
                        blen_d     = 2'd1;
                        bcnt_d     = 1'b0;
                        consume_rf = 1'b1;
                        state_d    = StSend;
                    end else if (alu_pend_q) begin
                        shreg_d     = alu_slot_q;
                        blen_d      = 2'd2;
                        bcnt_d      = 1'b0;
                        consume_alu = 1'b1;
                        state_d     = StSend;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A slot being consumed this edge counts as free for a new request.
        if (bus.rf_vld && !rf_direct) begin
            if (rf_pend_q && !consume_rf) begin
                req_ovf_d = 1'b1;
            end else begin
                rf_pend_d = 1'b1;
                rf_slot_d = bus.rf_data;
            end
        end else if (consume_rf) begin
            rf_pend_d = 1'b0;
        end

        if (bus.alu_vld && !alu_direct) begin
            if (alu_pend_q && !consume_alu) begin
                req_ovf_d = 1'b1;
            end else begin
                alu_pend_d = 1'b1;
                alu_slot_d = bus.alu_data;
            end
        end else if (consume_alu) begin
            alu_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bcnt_q     <= 1'b0;
            blen_q     <= 2'd0;
            rf_pend_q  <= 1'b0;
            rf_slot_q  <= '0;
            alu_pend_q <= 1'b0;
            alu_slot_q <= '0;
            req_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            blen_q     <= blen_d;
            rf_pend_q  <= rf_pend_d;
            rf_slot_q  <= rf_slot_d;
            alu_pend_q <= alu_pend_d;
            alu_slot_q <= alu_slot_d;
            req_ovf_q  <= req_ovf_d;
        end
    end

    assign bus.tx_d_vld  = (state_q == StSend);
    assign bus.tx_p_data = shreg_q[DATA_WIDTH-1:0];
    assign bus.ctrl_busy = (state_q != StIdle) || rf_pend_q || alu_pend_q;
    assign bus.req_ovf   = req_ovf_q;
endmodule

// File: tb/tb_ctrl_tx.sv
// Self-checking bench for ctrl_tx: a UART TX model answers each byte, expected
// bytes are queued when requests are driven and compared as bytes are accepted.
module tb_ctrl_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_tx_if #(.DATA_WIDTH(8), .ALU_WIDTH(16)) bus ();

    ctrl_tx #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    int         phase       = 0;
    int         hold        = 0;
    int         vld_cnt     = 0;
    bit         expect_next = 1'b0;
    logic [7:0] cur_byte    = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // UART TX model: busy rises in the second cycle of valid, stays 10 cycles.
    initial begin
        logic [7:0] b;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.tx_busy = 1'b0;
                phase       = 0;
                expect_next = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (expect_next) begin
                            check("gap", 32'(bus.tx_d_vld), 32'd1);
                            expect_next = 1'b0;
                        end
                        if (bus.tx_d_vld) begin
                            cur_byte = bus.tx_p_data;
                            if (exp_q.size() == 0) begin
                                check("extra_byte", 32'(cur_byte) | 32'h100, 32'h0);
                            end else begin
                                b = exp_q.pop_front();
                                check("byte", 32'(cur_byte), 32'(b));
                            end
                            vld_cnt = 1;
                            phase   = 1;
                        end
                    end
                    1: begin
                        if (bus.tx_d_vld) begin
                            vld_cnt++;
                            check("pdata_stable", 32'(bus.tx_p_data), 32'(cur_byte));
                        end
                        bus.tx_busy = 1'b1;
                        hold        = 10;
                        phase       = 2;
                    end
                    default: begin
                        if (bus.tx_d_vld) vld_cnt++;
                        hold--;
                        if (hold == 0) begin
                            bus.tx_busy = 1'b0;
                            phase       = 0;
                            check("vld_cycles", 32'(vld_cnt), 32'd2);
                            expect_next = (exp_q.size() != 0);
                        end
                    end
                endcase
            end
        end
    end

    task automatic pulse(input bit do_rf, input logic [7:0] rd,
                         input bit do_alu, input logic [15:0] ad);
        @(posedge clk);
        #1;
        bus.rf_vld   = do_rf;
        bus.rf_data  = rd;
        bus.alu_vld  = do_alu;
        bus.alu_data = ad;
        @(posedge clk);
        #1;
        bus.rf_vld  = 1'b0;
        bus.alu_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || phase != 0 || bus.ctrl_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_timeout", tag), 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        check($sformatf("%s_idle_busy", tag), 32'(bus.ctrl_busy), 32'd0);
        check($sformatf("%s_idle_vld", tag), 32'(bus.tx_d_vld), 32'd0);
    endtask

    initial begin
        int n;
        bus.rf_vld   = 1'b0;
        bus.rf_data  = 8'h00;
        bus.alu_vld  = 1'b0;
        bus.alu_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pdata", 32'(bus.tx_p_data), 32'd0);
        check("rst_vld", 32'(bus.tx_d_vld), 32'd0);
        check("rst_busy", 32'(bus.ctrl_busy), 32'd0);
        check("rst_ovf", 32'(bus.req_ovf), 32'd0);
        rst = 1'b1;

        // RF single byte with latency check
        exp_q.push_back(8'h5A);
        pulse(1'b1, 8'h5A, 1'b0, 16'h0);
        @(negedge clk);
        check("latency", 32'(bus.tx_d_vld), 32'd1);
        wait_done("rf");

        // ALU frame, low byte first
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        pulse(1'b0, 8'h00, 1'b1, 16'hBEEF);
        wait_done("alu");

        // Simultaneous RF and ALU
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h22);
        pulse(1'b1, 8'h11, 1'b1, 16'h2233);
        wait_done("sim");
        check("ovf_sim", 32'(bus.req_ovf), 32'd0);

        // Overflow: second RF while slot full is dropped
        exp_q.push_back(8'hBB);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h44);
        pulse(1'b0, 8'h00, 1'b1, 16'hAABB);
        pulse(1'b1, 8'h44, 1'b0, 16'h0);
        pulse(1'b1, 8'h55, 1'b0, 16'h0);
        @(negedge clk);
        check("ovf_set", 32'(bus.req_ovf), 32'd1);
        wait_done("ovf");
        check("ovf_sticky", 32'(bus.req_ovf), 32'd1);

        // Priority: pending RF goes before pending ALU
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h99);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        pulse(1'b1, 8'h01, 1'b0, 16'h0);
        pulse(1'b0, 8'h00, 1'b1, 16'h1234);
        pulse(1'b1, 8'h99, 1'b0, 16'h0);
        wait_done("prio");

        // Reset during WAIT_DONE of the first ALU byte
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
        pulse(1'b0, 8'h00, 1'b1, 16'hC3A5);
        n = 0;
        while (phase != 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
        check("rst_first_sent", 32'(exp_q.size()), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_vld", 32'(bus.tx_d_vld), 32'd0);
        check("mid_rst_pdata", 32'(bus.tx_p_data), 32'd0);
        check("mid_rst_busy", 32'(bus.ctrl_busy), 32'd0);
        check("mid_rst_ovf", 32'(bus.req_ovf), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", 32'(bus.ctrl_busy), 32'd0);
        check("post_rst_vld", 32'(bus.tx_d_vld), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
